// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg
//   Shared types and defaults for the router output-side arbiters.
//   - DATA_W_DEF  : default packet width in bits
//   - arb_state_t : output arbiter FSM encoding
// ---------------------------------------------------------------------------
package noc_pkg;

  localparam int DATA_W_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } arb_state_t;

endpackage : noc_pkg

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Searches req starting at last+1 and
//   wrapping modulo N; reports the first set bit.
//   Ports:
//     req  [N-1:0]  request vector
//     last [W-1:0]  index granted most recently (lowest priority next)
//     any           at least one request is set
//     idx  [W-1:0]  selected index (0 when any=0)
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         any,
  output logic [W-1:0] idx
);

  // Walk from farthest to nearest so the nearest hit after 'last' is the one
  // that sticks; avoids a loop break.
  always_comb begin
    int j;
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(last) + k) % N;
      if (req[j]) begin
        any = 1'b1;
        idx = W'(j);
      end
    end
  end

endmodule : rr_pick

// File: rtl/noc_out_arbiter.sv
// ---------------------------------------------------------------------------
// noc_out_arbiter
//   Shares one router output port among NUM_IN input FIFOs. A round-robin
//   pick pulses rd_en for one cycle, the head packet is captured the next
//   cycle, then held on out_packet with so=1 until the downstream ro.
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     req             per-FIFO not-empty (and routed here)
//     fifo_data       head data, slice i = [i*DATA_W +: DATA_W]
//     rd_en           one-hot read strobe to the granted FIFO
//     so / ro         send-valid / downstream ready
//     out_packet      packet presented with so
//     grant_id        input owning the current packet
//     pkt_count       completed transfers, wraps
// ---------------------------------------------------------------------------
module noc_out_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16,
  localparam int IDX_W = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        req,
  input  logic [NUM_IN*DATA_W-1:0] fifo_data,
  output logic [NUM_IN-1:0]        rd_en,
  output logic                     so,
  input  logic                     ro,
  output logic [DATA_W-1:0]        out_packet,
  output logic [IDX_W-1:0]         grant_id,
  output logic [CNT_W-1:0]         pkt_count
);

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_grant;
  logic [DATA_W-1:0]  r_out;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_any;
  logic [IDX_W-1:0]   w_idx;
  logic               w_pick;
  logic               w_xfer;

  rr_pick #(.N(NUM_IN)) u_rr_pick (
    .req  (req),
    .last (r_last),
    .any  (w_any),
    .idx  (w_idx)
  );

  // A new pick is only allowed when out_packet is empty (IDLE) or is being
  // handed off this very edge (SEND with ro), which keeps one packet in flight.
  always_comb begin
    w_next = r_state;
    w_pick = 1'b0;
    w_xfer = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_pick = 1'b1;
          w_next = FETCH;
        end
      end
      FETCH: begin
        w_next = SEND;
      end
      SEND: begin
        if (ro) begin
          w_xfer = 1'b1;
          if (w_any) begin
            w_pick = 1'b1;
            w_next = FETCH;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= IDX_W'(NUM_IN - 1);
      r_grant <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_pick) begin
        r_grant <= w_idx;
        r_last  <= w_idx;
      end
      // FIFO head is valid the cycle after its rd_en pulse.
      if (r_state == FETCH) begin
        r_out <= fifo_data[r_grant*DATA_W +: DATA_W];
      end
      if (w_xfer) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign rd_en      = w_pick ? (NUM_IN'(1) << w_idx) : '0;
  assign so         = (r_state == SEND);
  assign out_packet = r_out;
  assign grant_id   = r_grant;
  assign pkt_count  = r_cnt;

endmodule : noc_out_arbiter

// File: tb/tb_noc_out_arbiter.sv
module tb_noc_out_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] fifo_data;
  logic [N-1:0]    rd_en;
  logic            so;
  logic            ro;
  logic [DW-1:0]   out_packet;
  logic [1:0]      grant_id;
  logic [15:0]     pkt_count;

  // narrow-counter copy, same stimulus, used to exercise counter wrap quickly
  logic [N-1:0]    s_rd_en;
  logic            s_so;
  logic [DW-1:0]   s_out_packet;
  logic [1:0]      s_grant_id;
  logic [2:0]      s_pkt_count;

  int n_tests = 0;
  int n_fail  = 0;

  noc_out_arbiter #(.NUM_IN(N), .DATA_W(DW), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .fifo_data  (fifo_data),
    .rd_en      (rd_en),
    .so         (so),
    .ro         (ro),
    .out_packet (out_packet),
    .grant_id   (grant_id),
    .pkt_count  (pkt_count)
  );

  noc_out_arbiter #(.NUM_IN(N), .DATA_W(DW), .CNT_W(3)) dut_small (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .fifo_data  (fifo_data),
    .rd_en      (s_rd_en),
    .so         (s_so),
    .ro         (ro),
    .out_packet (s_out_packet),
    .grant_id   (s_grant_id),
    .pkt_count  (s_pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    ro    = 1'b0;
    fifo_data = '0;
    fifo_data[0*DW +: DW] = 64'hA5;
    fifo_data[1*DW +: DW] = 64'h1001;
    fifo_data[2*DW +: DW] = 64'h1002;
    fifo_data[3*DW +: DW] = 64'h1003;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_so", so, 0);
    chk("rst_out", out_packet, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_cnt", pkt_count, 0);
    chk("rst_cnt_small", s_pkt_count, 0);

    // single request, basic latency; req drops after grant
    req = 4'b0001;
    ro  = 1'b1;
    #1;
    chk("t1_rd_en", rd_en, 4'b0001);
    tick();
    req = 4'b0000;
    #1;
    chk("t1_fetch_rd_en", rd_en, 0);
    chk("t1_fetch_so", so, 0);
    chk("t1_fetch_grant", grant_id, 0);
    tick();
    #1;
    chk("t1_send_so", so, 1);
    chk("t1_send_out", out_packet, 64'hA5);
    chk("t1_send_grant", grant_id, 0);
    chk("t1_send_cnt", pkt_count, 0);
    tick();
    #1;
    chk("t1_done_so", so, 0);
    chk("t1_done_cnt", pkt_count, 1);

    // fresh pointer: all requesting, order 0,1,2,3,0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fifo_data[0*DW +: DW] = 64'h1000;
    #1;
    chk("t2_rst_cnt", pkt_count, 0);
    req = 4'b1111;
    #1;
    chk("t2_rd_en0", rd_en, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk("t2_fetch_so", so, 0);
      chk("t2_fetch_rd_en", rd_en, 0);
      chk("t2_fetch_grant", grant_id, 64'(k % 4));
      tick();
      #1;
      chk("t2_send_so", so, 1);
      chk("t2_send_out", out_packet, 64'h1000 + 64'(k % 4));
      chk("t2_send_cnt", pkt_count, 64'(k));
      chk("t2_send_rd_en", rd_en, 64'(1 << ((k + 1) % 4)));
    end
    req = 4'b0000;
    tick();
    #1;
    chk("t2_end_so", so, 0);
    chk("t2_end_cnt", pkt_count, 5);

    // last=0, req=0101: pick 2, then wrap past 3 to 0
    req = 4'b0101;
    #1;
    chk("t3_rd_en_a", rd_en, 4'b0100);
    tick();
    #1;
    chk("t3_grant_a", grant_id, 2);
    tick();
    #1;
    chk("t3_out_a", out_packet, 64'h1002);
    chk("t3_rd_en_b", rd_en, 4'b0001);
    tick();
    req = 4'b0000;
    #1;
    chk("t3_grant_b", grant_id, 0);
    chk("t3_cnt", pkt_count, 6);
    tick();
    #1;
    chk("t3_send_so", so, 1);
    chk("t3_out_b", out_packet, 64'h1000);

    // backpressure: held for 5 cycles even with requests pending
    ro  = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      chk("t4_hold_so", so, 1);
      chk("t4_hold_out", out_packet, 64'h1000);
      chk("t4_hold_rd_en", rd_en, 0);
      chk("t4_hold_cnt", pkt_count, 6);
    end
    ro  = 1'b1;
    req = 4'b0000;
    tick();
    #1;
    chk("t4_rel_so", so, 0);
    chk("t4_rel_cnt", pkt_count, 7);

    // reset while a packet waits in SEND
    req = 4'b1000;
    ro  = 1'b0;
    #1;
    chk("t5_rd_en", rd_en, 4'b1000);
    tick();
    req = 4'b0000;
    tick();
    #1;
    chk("t5_send_so", so, 1);
    chk("t5_send_grant", grant_id, 3);
    chk("t5_send_out", out_packet, 64'h1003);
    reset = 1'b1;
    tick();
    #1;
    chk("t5_rst_so", so, 0);
    chk("t5_rst_cnt", pkt_count, 0);
    chk("t5_rst_out", out_packet, 0);
    chk("t5_rst_grant", grant_id, 0);
    reset = 1'b0;
    req   = 4'b1111;
    #1;
    chk("t5_prio0", rd_en, 4'b0001);

    // single requester granted back to back
    req = 4'b0010;
    ro  = 1'b1;
    #1;
    chk("t6_rd_en_a", rd_en, 4'b0010);
    tick();
    tick();
    #1;
    chk("t6_out", out_packet, 64'h1001);
    chk("t6_rd_en_b", rd_en, 4'b0010);
    tick();
    #1;
    chk("t6_grant", grant_id, 1);
    chk("t6_cnt_a", pkt_count, 1);
    tick();
    req = 4'b0000;
    #1;
    chk("t6_send_so", so, 1);
    tick();
    #1;
    chk("t6_cnt_b", pkt_count, 2);
    chk("t6_idle_so", so, 0);

    // counter wrap on the 3-bit copy: 2 -> 7 -> 0
    req = 4'b0001;
    repeat (12) tick();
    chk("t7_so", so, 1);
    chk("t7_cnt", pkt_count, 7);
    chk("t7_cnt_small", s_pkt_count, 7);
    req = 4'b0000;
    tick();
    chk("t7_cnt_after", pkt_count, 8);
    chk("t7_wrap_small", s_pkt_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_noc_out_arbiter
